// File: rtl/mc_dp_pkg.sv
// Shared types and instruction field positions for the mc_datapath core.
package mc_dp_pkg;

  localparam int unsigned ILEN   = 16;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned RD_LSB = 9;
  localparam int unsigned RA_LSB = 6;
  localparam int unsigned RB_LSB = 3;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned IMM_W  = 6;
  localparam int unsigned NREGS  = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_BEQ  = 4'h9,
    OP_JMP  = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  // Opcodes B..E have no defined meaning and stop the core.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

  function automatic logic sets_flags(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_dp_alu.sv
// Combinational ALU: add/sub/logic ops with {Z,N,C,V} flag generation.
module mc_dp_alu
  import mc_dp_pkg::*;
#(
  parameter int unsigned XLEN = 16
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags
);

  localparam int unsigned MSB = XLEN - 1;

  logic [XLEN:0] sum;
  flags_t        f;

  always_comb begin
    sum    = '0;
    result = '0;
    f      = '0;
    case (opcode_e'(op))
      OP_ADD, OP_ADDI: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[XLEN-1:0];
        f.c    = sum[XLEN];
        f.v    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      // Carry out of a + ~b + 1 is the inverted borrow.
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
        result = sum[XLEN-1:0];
        f.c    = sum[XLEN];
        f.v    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
    f.z = (result == '0);
    f.n = result[MSB];
  end

  assign flags = f;

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle 16-bit-instruction CPU core with req/ack instruction and data ports.
// Optional MC_DATAPATH_PERF_EN adds cyc_cnt/inst_cnt performance counters.
module mc_datapath
  import mc_dp_pkg::*;
#(
  parameter int unsigned   XLEN     = 16,
  parameter int unsigned   AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [AW-1:0]   dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire,
  output logic            halted,
  output logic            illegal,
  output logic [AW-1:0]   pc_o,
  output logic [3:0]      flags_o
`ifdef MC_DATAPATH_PERF_EN
  ,
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     inst_cnt
`endif
);

  state_e            state_q, state_d;
  logic [ILEN-1:0]   ir_q;
  logic [XLEN-1:0]   a_q, b_q, d_q, imm_q, acc_q, mdr_q;
  flags_t            flags_q;
  logic [AW-1:0]     pc_q;
  logic [XLEN-1:0]   regs [NREGS];

  logic [3:0]        op_raw;
  opcode_e           op;
  logic [REG_W-1:0]  rd, ra, rb;
  logic [XLEN-1:0]   imm_ext, rf_a, rf_b, rf_d;
  logic [XLEN-1:0]   alu_b, alu_res, ea, br_tgt;
  logic [3:0]        alu_flags;
  logic              imem_fire, dmem_fire, retire_d, illegal_d;

  assign op_raw  = ir_q[OP_LSB +: OP_W];
  assign op      = opcode_e'(op_raw);
  assign rd      = ir_q[RD_LSB +: REG_W];
  assign ra      = ir_q[RA_LSB +: REG_W];
  assign rb      = ir_q[RB_LSB +: REG_W];
  assign imm_ext = {{(XLEN-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

  assign rf_a = (ra == '0) ? '0 : regs[ra];
  assign rf_b = (rb == '0) ? '0 : regs[rb];
  assign rf_d = (rd == '0) ? '0 : regs[rd];

  // A late ack with no request outstanding must not advance the sequencer.
  assign imem_fire = imem_req & imem_ack;
  assign dmem_fire = dmem_req & dmem_ack;

  assign alu_b  = (op == OP_ADDI) ? imm_q : b_q;
  assign ea     = a_q + imm_q;
  assign br_tgt = XLEN'(pc_q) + XLEN'(1) + imm_q;

  assign imem_addr = pc_q;
  assign pc_o      = pc_q;
  assign flags_o   = flags_q;

  mc_dp_alu #(.XLEN(XLEN)) u_alu (
    .op     (op_raw),
    .a      (a_q),
    .b      (alu_b),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      FETCH:  if (imem_fire) state_d = DECODE;
      DECODE: begin
        if (is_illegal(op_raw)) begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end else if (op == OP_HALT) begin
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op)
          OP_NOP, OP_BEQ, OP_JMP: begin
            state_d  = FETCH;
            retire_d = 1'b1;
          end
          OP_LD, OP_ST: state_d = MEM;
          default:      state_d = WB;
        endcase
      end
      MEM: begin
        if (dmem_fire) begin
          state_d  = (op == OP_ST) ? FETCH : WB;
          retire_d = (op == OP_ST);
        end
      end
      WB: begin
        state_d  = FETCH;
        retire_d = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Request flops track the next state so req rises on entry and falls right after ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      retire   <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      imem_req <= (state_d == FETCH);
      dmem_req <= (state_d == MEM);
      retire   <= retire_d;
      halted   <= (state_d == HALT);
      illegal  <= illegal | illegal_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      d_q        <= '0;
      imm_q      <= '0;
      acc_q      <= '0;
      mdr_q      <= '0;
      flags_q    <= '0;
      pc_q       <= RESET_PC;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state_q)
        FETCH: if (imem_fire) ir_q <= imem_rdata;
        DECODE: begin
          a_q   <= rf_a;
          b_q   <= rf_b;
          d_q   <= rf_d;
          imm_q <= imm_ext;
        end
        EXEC: begin
          acc_q <= alu_res;
          if (sets_flags(op)) flags_q <= flags_t'(alu_flags);
          case (op)
            OP_BEQ:  pc_q <= (d_q == a_q) ? AW'(br_tgt) : pc_q + AW'(1);
            OP_JMP:  pc_q <= AW'(a_q);
            default: pc_q <= pc_q + AW'(1);
          endcase
          if ((op == OP_LD) || (op == OP_ST)) begin
            dmem_addr  <= AW'(ea);
            dmem_we    <= (op == OP_ST);
            dmem_wdata <= d_q;
          end
        end
        MEM: if (dmem_fire) mdr_q <= dmem_rdata;
        default: ;
      endcase
    end
  end

  // Register file; r0 is never written and reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if ((state_q == WB) && (rd != '0)) begin
      regs[rd] <= (op == OP_LD) ? mdr_q : acc_q;
    end
  end

`ifdef MC_DATAPATH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      if (!halted) cyc_cnt  <= cyc_cnt + 32'd1;
      if (retire)  inst_cnt <= inst_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: ISA-level reference model, memory responders with wait-states.
module tb_mc_datapath;
  import mc_dp_pkg::*;

  localparam int unsigned XLEN = 16;
  localparam int unsigned AW   = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            imem_req, imem_ack;
  logic [AW-1:0]   imem_addr;
  logic [15:0]     imem_rdata;
  logic            dmem_req, dmem_we, dmem_ack;
  logic [AW-1:0]   dmem_addr;
  logic [XLEN-1:0] dmem_wdata, dmem_rdata;
  logic            retire, halted, illegal;
  logic [AW-1:0]   pc_o;
  logic [3:0]      flags_o;
`ifdef MC_DATAPATH_PERF_EN
  logic [31:0]     cyc_cnt, inst_cnt;
`endif

  mc_datapath #(.XLEN(XLEN), .AW(AW), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .retire(retire), .halted(halted), .illegal(illegal), .pc_o(pc_o), .flags_o(flags_o)
`ifdef MC_DATAPATH_PERF_EN
    , .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
`endif
  );

  // 8-bit ALU instance for narrow-width flag behaviour.
  logic [3:0] a8op, a8f;
  logic [7:0] a8a, a8b, a8r;
  mc_dp_alu #(.XLEN(8)) u_alu8 (.op(a8op), .a(a8a), .b(a8b), .result(a8r), .flags(a8f));

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Program image, DUT-side data memory, and the reference model state.
  logic [15:0] prog [256];
  logic [15:0] dmem [logic [15:0]];
  logic [15:0] m_mem [logic [15:0]];
  logic [15:0] m_rf [8];
  logic [15:0] m_pc;
  logic [3:0]  m_flags;

  int  imem_delay = 0, dmem_delay = 0;
  bit  force_iack = 0;
  int  ret_cyc[$];
  logic [3:0] ret_flags[$];

  function automatic logic [15:0] rr(input int op, input int rd, input int ra, input int rb);
    return {op[3:0], rd[2:0], ra[2:0], rb[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] ri(input int op, input int rd, input int ra, input int imm);
    return {op[3:0], rd[2:0], ra[2:0], imm[5:0]};
  endfunction

  function automatic logic [15:0] rd_dmem(input logic [15:0] a);
    return dmem.exists(a) ? dmem[a] : 16'h0;
  endfunction

  function automatic void model_reset();
    m_pc = 16'h0;
    m_flags = 4'h0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
  endfunction

  // Executes one instruction from the architectural rules.
  function automatic void model_step();
    logic [15:0] ins, va, vb, vd, imm, bop, res, addr;
    int op, rd, ra, rb, ua, ub, sa, sb, sr;
    bit wr, fl, c, v;
    ins = prog[m_pc[7:0]];
    op = int'(ins[15:12]); rd = int'(ins[11:9]); ra = int'(ins[8:6]); rb = int'(ins[5:3]);
    imm = {{10{ins[5]}}, ins[5:0]};
    va = m_rf[ra]; vb = m_rf[rb]; vd = m_rf[rd];
    bop = (op == 6) ? imm : vb;
    ua = int'(va); ub = int'(bop);
    sa = int'($signed(va)); sb = int'($signed(bop));
    res = 16'h0; wr = 0; fl = 0; c = 0; v = 0;
    m_pc = m_pc + 16'h1;
    case (op)
      1, 6: begin res = va + bop; c = (ua + ub) > 65535; sr = sa + sb;
                  v = (sr > 32767) || (sr < -32768); wr = 1; fl = 1; end
      2: begin res = va - bop; c = (ua >= ub); sr = sa - sb;
               v = (sr > 32767) || (sr < -32768); wr = 1; fl = 1; end
      3: begin res = va & vb; wr = 1; fl = 1; end
      4: begin res = va | vb; wr = 1; fl = 1; end
      5: begin res = va ^ vb; wr = 1; fl = 1; end
      7: begin addr = va + imm; res = m_mem.exists(addr) ? m_mem[addr] : 16'h0; wr = 1; end
      8: begin addr = va + imm; m_mem[addr] = vd; end
      9: if (vd == va) m_pc = m_pc + imm;
      10: m_pc = va;
      default: ;
    endcase
    if (wr && rd != 0) m_rf[rd] = res;
    if (fl) m_flags = {res == 16'h0, res[15], c, v};
  endfunction

  // Instruction memory responder with programmable wait-states.
  int  iw_cnt = 0;
  bit  i_busy = 0;
  logic [15:0] i_snap;
  always @(negedge clk) begin
    if (force_iack) begin
      imem_ack = 1'b1;
      imem_rdata = 16'hC000;
    end else if (rst || !imem_req) begin
      imem_ack = 1'b0; iw_cnt = 0; i_busy = 0;
    end else begin
      if (i_busy) chk("imem_addr_stable", imem_addr, i_snap);
      else begin i_busy = 1; i_snap = imem_addr; end
      if (iw_cnt >= imem_delay) begin
        imem_ack = 1'b1; imem_rdata = prog[imem_addr[7:0]];
      end else begin
        imem_ack = 1'b0; iw_cnt++;
      end
    end
  end

  // Data memory responder; checks addr/we/wdata hold while req is high.
  int  dw_cnt = 0;
  bit  d_busy = 0;
  logic [32:0] d_snap;
  always @(negedge clk) begin
    if (rst || !dmem_req) begin
      dmem_ack = 1'b0; dw_cnt = 0; d_busy = 0;
    end else begin
      if (d_busy) chk("dmem_sig_stable", {dmem_we, dmem_addr, dmem_wdata}, d_snap);
      else begin d_busy = 1; d_snap = {dmem_we, dmem_addr, dmem_wdata}; end
      if (dw_cnt >= dmem_delay) begin
        dmem_ack = 1'b1;
        if (dmem_we) dmem[dmem_addr] = dmem_wdata;
        else dmem_rdata = rd_dmem(dmem_addr);
      end else begin
        dmem_ack = 1'b0; dw_cnt++;
      end
    end
  end

  task automatic begin_test();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
    dmem.delete();
    m_mem.delete();
    model_reset();
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    dmem[a] = d;
    m_mem[a] = d;
  endtask

  task automatic release_rst();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_prog(input int max_cyc, input bit expect_halt);
    int n;
    logic [3:0] hop;
    n = 0;
    ret_cyc.delete();
    ret_flags.delete();
    while (n < max_cyc && !halted) begin
      @(negedge clk);
      n++;
      if (retire) begin
        ret_cyc.push_back(n);
        ret_flags.push_back(flags_o);
        model_step();
        chk("retire_pc", pc_o, m_pc);
        chk("retire_flags", flags_o, m_flags);
      end
    end
    if (expect_halt) begin
      chk("halt_reached", halted, 1);
      if (halted) begin
        hop = prog[m_pc[7:0]][15:12];
        chk("halt_pc", pc_o, m_pc);
        chk("halt_illegal", illegal, (hop >= 4'hB && hop <= 4'hE));
      end
    end
  endtask

  task automatic cmp_mem();
    chk("mem_entries", dmem.num(), m_mem.num());
    foreach (m_mem[k]) chk($sformatf("mem_%0h", k), rd_dmem(k), m_mem[k]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, rd, ra, rb, imm, s, sv;
    logic [7:0]  r8;
    bit c8, v8, any_req;

    imem_ack = 0; imem_rdata = 0; dmem_ack = 0; dmem_rdata = 0;
    a8op = 0; a8a = 0; a8b = 0;

    // Reset state
    begin_test();
    @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_retire", retire, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_flags", flags_o, 0);

    // ADDI/ADDI/ADD: r3 = 2, C set, one retire every 4 cycles
    prog[0] = ri(6, 1, 0, 5);
    prog[1] = ri(6, 2, 0, -3);
    prog[2] = rr(1, 3, 1, 2);
    prog[3] = ri(8, 3, 0, 0);
    release_rst();
    run_prog(200, 1);
    chk("add_retires", ret_cyc.size() >= 3, 1);
    if (ret_cyc.size() >= 3) begin
      chk("add_spacing_1", ret_cyc[1] - ret_cyc[0], 4);
      chk("add_spacing_2", ret_cyc[2] - ret_cyc[1], 4);
      chk("add_flags", ret_flags[2], 4'b0010);
    end
    chk("add_result", rd_dmem(16'h0), 16'h2);
    chk("halt_no_illegal", illegal, 0);
    cmp_mem();

    // SUB to zero, then 0x7FFF + 1 signed overflow
    begin_test();
    poke(16'h5, 16'h7FFF);
    prog[0] = ri(6, 1, 0, 7);
    prog[1] = rr(2, 1, 1, 1);
    prog[2] = ri(8, 1, 0, 1);
    prog[3] = ri(7, 2, 0, 5);
    prog[4] = ri(6, 3, 2, 1);
    prog[5] = ri(8, 3, 0, 2);
    release_rst();
    run_prog(300, 1);
    chk("sub_retires", ret_flags.size(), 6);
    if (ret_flags.size() >= 5) begin
      chk("sub_flags", ret_flags[1], 4'b1010);
      chk("ovf_flags", ret_flags[4], 4'b0101);
    end
    chk("ovf_result", rd_dmem(16'h2), 16'h8000);
    cmp_mem();

    // 8-bit ALU: directed overflow then random add/sub
    a8op = 4'h1; a8a = 8'h7F; a8b = 8'h01; #1;
    chk("alu8_ovf_res", a8r, 8'h80);
    chk("alu8_ovf_flags", a8f, 4'b0101);
    for (int i = 0; i < 8; i++) begin
      a8a = 8'($urandom); a8b = 8'($urandom); a8op = (i % 2 == 1) ? 4'h2 : 4'h1; #1;
      if (a8op == 4'h1) begin
        s = int'(a8a) + int'(a8b); c8 = (s > 255);
        sv = int'($signed(a8a)) + int'($signed(a8b));
      end else begin
        s = int'(a8a) - int'(a8b); c8 = (a8a >= a8b);
        sv = int'($signed(a8a)) - int'($signed(a8b));
      end
      v8 = (sv > 127) || (sv < -128);
      r8 = s[7:0];
      chk("alu8_res", a8r, r8);
      chk("alu8_flags", a8f, {r8 == 8'h0, r8[7], c8, v8});
    end

    // Store/load round trip with a 3-cycle data wait
    begin_test();
    dmem_delay = 3;
    prog[0] = ri(6, 1, 0, 9);
    prog[1] = ri(8, 1, 0, 4);
    prog[2] = ri(7, 2, 0, 4);
    prog[3] = ri(8, 2, 0, 6);
    release_rst();
    run_prog(300, 1);
    chk("ldst_r2", rd_dmem(16'h6), 16'h9);
    cmp_mem();
    dmem_delay = 0;

    // BEQ r0,r0,-1 at PC 10 spins in place
    begin_test();
    for (int i = 0; i < 10; i++) prog[i] = 16'h0000;
    prog[10] = ri(9, 0, 0, -1);
    release_rst();
    run_prog(80, 0);
    chk("beq_loop_pc", pc_o, 16'd10);
    chk("beq_loop_running", halted, 0);
    chk("beq_loop_retired", ret_cyc.size() > 12, 1);

    // JMP through r4 = 0x20
    begin_test();
    prog[0] = ri(6, 4, 0, 16);
    prog[1] = rr(1, 4, 4, 4);
    prog[2] = rr(10, 0, 4, 0);
    for (int i = 3; i < 32; i++) prog[i] = 16'hC000;
    prog[32] = 16'hF000;
    release_rst();
    run_prog(200, 1);
    chk("jmp_target", imem_addr, 16'h20);
    chk("jmp_no_illegal", illegal, 0);

    // Illegal opcode halts with illegal set and stops all requests
    begin_test();
    prog[0] = ri(6, 1, 0, 1);
    prog[1] = 16'hC000;
    release_rst();
    run_prog(100, 1);
    chk("ill_halted", halted, 1);
    chk("ill_flag", illegal, 1);
    any_req = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      any_req = any_req | imem_req | dmem_req;
    end
    chk("ill_no_req", any_req, 0);

    // HALT opcode halts without illegal; reset clears the sticky flag
    begin_test();
    prog[0] = 16'hF000;
    release_rst();
    run_prog(50, 1);
    chk("halt_halted", halted, 1);
    chk("halt_illegal_clear", illegal, 0);

    // Reset in the middle of a stalled fetch, then a stray ack
    begin_test();
    imem_delay = 5;
    prog[0] = ri(6, 1, 0, 3);
    prog[1] = ri(8, 1, 0, 7);
    release_rst();
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    chk("mid_fetch_req", imem_req, 1);
    #2 rst = 1'b1;
    force_iack = 1;
    #1;
    chk("async_rst_req", imem_req, 0);
    chk("async_rst_pc", pc_o, 16'h0);
    model_reset();
    release_rst();
    @(posedge clk);
    #1 force_iack = 0;
    imem_delay = 0;
    run_prog(300, 1);
    chk("late_ack_ignored", illegal, 0);
    chk("post_rst_store", rd_dmem(16'h7), 16'h3);
    cmp_mem();

    // Random programs against the reference model
    for (int t = 0; t < 4; t++) begin
      begin_test();
      imem_delay = $urandom_range(0, 2);
      dmem_delay = $urandom_range(0, 2);
      for (int i = 0; i < 40; i++) begin
        sel = $urandom_range(0, 10);
        rd = $urandom_range(0, 7); ra = $urandom_range(0, 7); rb = $urandom_range(0, 7);
        imm = $urandom_range(0, 63);
        case (sel)
          0:             prog[i] = 16'h0000;
          1, 2, 3, 4, 5: prog[i] = rr(sel, rd, ra, rb);
          6, 10:         prog[i] = ri(6, rd, ($urandom_range(0, 1) == 1) ? 0 : ra, imm);
          7:             prog[i] = ri(7, rd, ($urandom_range(0, 1) == 1) ? 0 : ra, imm);
          8:             prog[i] = ri(8, rd, ($urandom_range(0, 1) == 1) ? 0 : ra, imm);
          default:       prog[i] = ri(9, rd, ra, $urandom_range(0, 3));
        endcase
      end
      for (int i = 1; i < 8; i++) prog[39 + i] = ri(8, i, 0, 24 + i);
      release_rst();
      run_prog(4000, 1);
      cmp_mem();
    end
    imem_delay = 0;
    dmem_delay = 0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
